fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised fetch front-end for the pipelined CPU; replaces the single-cycle PC/DFF64/PC+4 path.
//  Owns the PC register and drives the instruction-memory address.
//  Buffers fetched {pc, instr} pairs in a DEPTH-entry circular queue feeding decode via valid/ready.
//  Supports branch redirect with full queue flush, and fetch stall.
// PARAMETERS
//  ADDR_W    64  PC / address width in bits
//  INSTR_W   32  instruction width in bits
//  DEPTH     4   queue entries; power of 2, >= 2
//  RESET_PC  0   PC value loaded on reset
//  PC_INC    4   sequential PC increment in bytes
// PORTS
//  clk             in   1                  clock; all state updates on posedge
//  reset           in   1                  synchronous, active-high
//  fetch_en        in   1                  1 = fetch allowed this cycle; 0 = hold PC, no enqueue
//  imem_addr       out  ADDR_W             = pc (combinational from PC register)
//  imem_instr      in   INSTR_W            instruction at imem_addr, valid in the same cycle (async read)
//  redirect_valid  in   1                  branch taken; load redirect_pc, flush queue
//  redirect_pc     in   ADDR_W             redirect target; bits [1:0] forced to 0 on load
//  deq_valid       out  1                  queue head valid (= !empty)
//  deq_ready       in   1                  decode accepts head this cycle
//  deq_instr       out  INSTR_W            head instruction (0 when empty)
//  deq_pc          out  ADDR_W             head PC (0 when empty)
//  count           out  $clog2(DEPTH+1)    entries currently held
//  full            out  1                  count == DEPTH
// BEHAVIOUR
//  Reset (any cycle, incl. mid-operation): pc<=RESET_PC, rd/wr ptrs<=0, count<=0; deq_valid=0, full=0,
//    deq_instr=0, deq_pc=0. Reset overrides redirect, enqueue and dequeue.
//  deq  = deq_valid & deq_ready.
//  enq  = fetch_en & !redirect_valid & (!full | deq); writes {pc, imem_instr} at wr_ptr, pc<=pc+PC_INC.
//    Full with deq in the same cycle: enqueue allowed (slot freed same edge).
//  Redirect (priority over enq): pc<={redirect_pc[ADDR_W-1:2],2'b00}; ptrs<=0, count<=0.
//    A deq in the redirect cycle is a completed handshake; remaining entries are discarded.
//  No redirect: count<=count+enq-deq; simultaneous enq+deq leaves count unchanged.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH; PC add wraps modulo 2^ADDR_W.
//  Outputs are registered-state only: deq_* taken from the head entry, no imem-to-deq bypass.
//  Latency: PC P presented at edge N enqueues at N+1; deq_valid=1 after N+1 (1 cycle fetch-to-valid).
//    Redirect at edge N: target enqueued at N+1, visible on deq_* after N+1.
//  Empty: deq_ready ignored, count never underflows. Full & !deq: PC held, imem_instr ignored.
//  fetch_en=0: PC and queue contents held; dequeue still operates.
//  Decode must not assume deq_* stable while deq_valid=0.
// TESTING
//  1. Reset 2 cycles, deq_ready=1, fetch_en=1 -> deq_pc 0,4,8,12 on consecutive cycles,
//     deq_instr matches the imem model.
//  2. deq_ready=0 for 6 cycles -> count 1,2,3,4,4,4; full=1; imem_addr holds 0x10;
//     release -> in-order drain, no loss or duplication.
//  3. Full + deq_ready=1 + fetch_en=1 -> count stays 4, one in / one out per cycle
//     across a pointer wrap.
//  4. Redirect to 0x403 with 3 queued -> next cycle count=0, deq_valid=0; one cycle later
//     deq_pc=0x400, then 0x404.
//  5. Redirect with deq_ready=1 on the same edge -> head accepted once, remaining entries flushed;
//     fetch_en=0 -> PC frozen.
//  6. Assert reset mid-stream with count=3 and redirect_valid=1 -> count=0, pc=RESET_PC;
//     repeat case 1 with ADDR_W=32, DEPTH=8.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch front-end: PC register, instruction-memory address, DEPTH-entry {pc, instr} queue to decode.
// One cycle fetch-to-valid; a full queue holds the PC unless the head drains on the same edge.
module fetch_queue_unit #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_INC   = 4,
  localparam int unsigned       PTR_W    = $clog2(DEPTH),
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [ADDR_W-1:0]  deq_pc,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic empty;
  logic deq;
  logic enq;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign deq   = !empty && deq_ready;
  // A full queue still accepts when its head leaves on the same edge.
  assign enq   = fetch_en && !redirect_valid && (!full || deq);

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        pc_d     = pc_q + ADDR_W'(PC_INC);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_addr = pc_q;
  assign deq_valid = !empty;
  assign deq_instr = empty ? '0 : instr_mem_q[rd_ptr_q];
  assign deq_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
